ysyx_24100006_clint_slave: RTL and testbench
============================================

Name: ysyx_24100006_clint_slave

Overview:
- AXI4 responder for the CLINT region; it is the slave-side endpoint that the crossbar's clint_axi_* port connects to.
- Holds a free-running 64-bit mtime counter advanced by a prescaler.
- Serves single-beat and burst reads from a per-transaction snapshot, and accepts single-beat writes to mtime.
- Read and write channels run independently.

Parameters:
- BASE_ADDR, 32'h0200_0000, first byte of CLINT window.
- WIN_SIZE, 32'h0001_0000, window length in bytes.
- TICK_DIV, 1, clk cycles per mtime increment (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  32  write address
- awlen  in  8  write burst length-1
- awsize  in  3  write beat size
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  last write beat
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  32  read address
- arlen  in  8  read burst length-1
- arsize  in  3  read beat size (ignored; always 32-bit data)
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  last read beat

Behaviour:
- Reset (reset=0, async) values:
  - mtime=0, prescaler=0.
  - Both FSMs in IDLE.
  - arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rlast=0, rdata=0, rresp=00, bresp=00.
- Address decode:
  - off = addr-BASE_ADDR.
  - A beat is valid iff addr is in [BASE_ADDR, BASE_ADDR+WIN_SIZE) and off[15:3]==0.
  - off[2]=0 selects mtime[31:0]; off[2]=1 selects mtime[63:32].
  - Invalid beat: data 0, resp 10.
- mtime:
  - Prescaler counts 0..TICK_DIV-1; mtime increments by 1 on wrap.
  - 64-bit wrap from all-ones to 0.
- Read FSM, states IDLE -> RDATA -> IDLE:
  - IDLE: arready=1. When arvalid&arready: latch araddr and beats=arlen+1, snapshot mtime (value before any same-cycle write/increment), move to RDATA.
  - arready=0 outside IDLE.
  - RDATA: rvalid=1 starting the cycle after AR acceptance, so latency is 1 cycle.
  - rdata/rresp come from the snapshot and the current beat address.
  - Beat address increments by 4 per accepted beat (INCR).
  - rlast=1 on final beat.
  - rdata, rresp, rlast stay stable while rvalid&!rready.
  - Final beat accepted: rvalid=0, rlast=0, return to IDLE, arready=1 the next cycle. No back-to-back overlap.
- Write FSM, states IDLE -> WDATA -> WRESP -> IDLE:
  - IDLE: awready=1, wready=0. On AW handshake: latch awaddr and awlen, go to WDATA.
  - WDATA: wready=1, each W beat accepted.
  - Update rule: only the first beat updates mtime, and only if awlen==0 and the address is valid. Bytes are merged per wstrb into the selected half.
  - Error rule: bresp=10 if awlen!=0 or the address is invalid; no update in that case.
  - Beat carrying wlast: go to WRESP.
  - WRESP: bvalid=1 with bresp held until bready, then IDLE.
- Priority:
  - A write update in the same cycle as a prescaler wrap wins: mtime takes the written value and the increment is dropped.
  - Prescaler is not reset by writes.
- A read snapshot captured in the same cycle as a write holds the pre-write value.
- Reset asserted mid-transaction aborts both FSMs immediately, with all outputs at reset values.

Test Plan:
- Reset release, TICK_DIV=1, idle 10 cycles, single read 0x0200_0000 -> rdata=10±1 at expected cycle, rresp=00, rlast=1, arready low exactly during RDATA.
- Write 0x0200_0004 data 0x0000_0005 wstrb 1111 awlen 0 -> bresp=00; read burst arlen=1 from 0x0200_0000 -> beat0 low word, beat1 0x0000_0005 (same snapshot), rlast only on beat1.
- Write lo=0xFFFF_FFFF hi=0xFFFF_FFFF, TICK_DIV=1 -> two cycles later read returns lo=0x0000_0000 or 1 and hi=0 (64-bit wrap).
- Read 0x0200_0010 -> rdata=0, rresp=10; write awlen=2 to 0x0200_0000 -> 3 W beats consumed, bresp=10, mtime unchanged.
- Hold rready=0 for 5 cycles on a read, and bready=0 for 5 cycles on a write -> rdata, rlast, bresp stable; no extra handshake.
- Assert reset mid-burst (after beat0) -> rvalid=0, mtime=0, arready=1 immediately; new read completes normally after release.

Source files
------------

// File: rtl/ysyx_24100006_clint_slave_if.sv
// AXI4 bus bundle between the crossbar's CLINT port and the CLINT responder.
// The master modport drives requests; the slave modport answers them.
interface ysyx_24100006_clint_slave_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arlen, arsize,
    output rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arlen, arsize,
    input  rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_24100006_clint_slave.sv
// CLINT AXI4 responder: prescaled 64-bit mtime, snapshot-based burst reads and
// single-beat mtime writes, with independent read and write state machines.
module ysyx_24100006_clint_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter logic [31:0] WIN_SIZE  = 32'h0001_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input logic clk,
  input logic reset,
  ysyx_24100006_clint_slave_if.slave bus
);

  localparam logic [31:0] PRESC_MAX = 32'(TICK_DIV - 1);
  localparam logic [32:0] WIN_END   = {1'b0, BASE_ADDR} + {1'b0, WIN_SIZE};

  // Only the 8 bytes at the bottom of the window map onto mtime.
  function automatic logic beat_ok(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && ({1'b0, addr} < WIN_END) &&
           (((addr - BASE_ADDR) & 32'h0000_FFF8) == 32'd0);
  endfunction

  function automatic logic beat_hi(input logic [31:0] addr);
    return ((addr - BASE_ADDR) & 32'h0000_0004) != 32'd0;
  endfunction

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

  rd_state_t   rd_state_reg, rd_state_next;
  logic [31:0] rd_addr_reg, rd_addr_next;
  logic [8:0]  rd_beats_reg, rd_beats_next;
  logic [63:0] snap_reg, snap_next;

  wr_state_t   wr_state_reg, wr_state_next;
  logic [31:0] wr_addr_reg, wr_addr_next;
  logic        wr_err_reg, wr_err_next;
  logic        wr_first_reg, wr_first_next;
  logic        mtime_wr_en;

  logic [63:0] mtime_reg, mtime_next;
  logic [31:0] presc_reg, presc_next;
  logic        tick;

  logic        rd_ok;
  logic        wr_hi;
  logic [31:0] half_old;
  logic [31:0] half_new;
  logic [63:0] mtime_wdata;

  logic unused_size;
  assign unused_size = ^{bus.awsize, bus.arsize};

  // Read channel: one snapshot per AR, beats walk the address by 4.
  always_comb begin
    rd_state_next = rd_state_reg;
    rd_addr_next  = rd_addr_reg;
    rd_beats_next = rd_beats_reg;
    snap_next     = snap_reg;
    case (rd_state_reg)
      RD_IDLE: begin
        if (bus.arvalid) begin
          rd_addr_next  = bus.araddr;
          rd_beats_next = {1'b0, bus.arlen} + 9'd1;
          snap_next     = mtime_reg;
          rd_state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.rready) begin
          if (rd_beats_reg == 9'd1) begin
            rd_state_next = RD_IDLE;
          end else begin
            rd_addr_next  = rd_addr_reg + 32'd4;
            rd_beats_next = rd_beats_reg - 9'd1;
          end
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  assign rd_ok       = beat_ok(rd_addr_reg);
  assign bus.arready = (rd_state_reg == RD_IDLE);
  assign bus.rvalid  = (rd_state_reg == RD_DATA);
  assign bus.rlast   = bus.rvalid && (rd_beats_reg == 9'd1);
  assign bus.rdata   = (bus.rvalid && rd_ok) ?
                       (beat_hi(rd_addr_reg) ? snap_reg[63:32] : snap_reg[31:0]) : 32'd0;
  assign bus.rresp   = (bus.rvalid && !rd_ok) ? 2'b10 : 2'b00;

  // Write channel: the error verdict is fixed at AW time; only the first beat may update.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_addr_next  = wr_addr_reg;
    wr_err_next   = wr_err_reg;
    wr_first_next = wr_first_reg;
    mtime_wr_en   = 1'b0;
    case (wr_state_reg)
      WR_IDLE: begin
        if (bus.awvalid) begin
          wr_addr_next  = bus.awaddr;
          wr_err_next   = (bus.awlen != 8'd0) || !beat_ok(bus.awaddr);
          wr_first_next = 1'b1;
          wr_state_next = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.wvalid) begin
          mtime_wr_en   = wr_first_reg && !wr_err_reg;
          wr_first_next = 1'b0;
          if (bus.wlast) begin
            wr_state_next = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (bus.bready) begin
          wr_state_next = WR_IDLE;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  assign bus.awready = (wr_state_reg == WR_IDLE);
  assign bus.wready  = (wr_state_reg == WR_DATA);
  assign bus.bvalid  = (wr_state_reg == WR_RESP);
  assign bus.bresp   = (bus.bvalid && wr_err_reg) ? 2'b10 : 2'b00;

  assign wr_hi    = beat_hi(wr_addr_reg);
  assign half_old = wr_hi ? mtime_reg[63:32] : mtime_reg[31:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_merge
      assign half_new[gi*8 +: 8] = bus.wstrb[gi] ? bus.wdata[gi*8 +: 8] : half_old[gi*8 +: 8];
    end
  endgenerate

  assign mtime_wdata = wr_hi ? {half_new, mtime_reg[31:0]} : {mtime_reg[63:32], half_new};

  // A write landing on a prescaler wrap swallows that increment.
  assign tick       = (presc_reg == PRESC_MAX);
  assign presc_next = tick ? 32'd0 : presc_reg + 32'd1;
  assign mtime_next = mtime_wr_en ? mtime_wdata :
                      tick        ? mtime_reg + 64'd1 : mtime_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_reg <= RD_IDLE;
      rd_addr_reg  <= 32'd0;
      rd_beats_reg <= 9'd0;
      snap_reg     <= 64'd0;
      wr_state_reg <= WR_IDLE;
      wr_addr_reg  <= 32'd0;
      wr_err_reg   <= 1'b0;
      wr_first_reg <= 1'b0;
      mtime_reg    <= 64'd0;
      presc_reg    <= 32'd0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_addr_reg  <= rd_addr_next;
      rd_beats_reg <= rd_beats_next;
      snap_reg     <= snap_next;
      wr_state_reg <= wr_state_next;
      wr_addr_reg  <= wr_addr_next;
      wr_err_reg   <= wr_err_next;
      wr_first_reg <= wr_first_next;
      mtime_reg    <= mtime_next;
      presc_reg    <= presc_next;
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_clint_slave.sv
// Scoreboard bench for the CLINT responder: a cycle model of mtime predicts every
// R/B response, and a negedge monitor checks them as the DUT presents them.
module tb_ysyx_24100006_clint_slave;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] WIN  = 32'h0001_0000;
  localparam int          TDIV = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ysyx_24100006_clint_slave_if bus();

  ysyx_24100006_clint_slave #(
    .BASE_ADDR(BASE),
    .WIN_SIZE (WIN),
    .TICK_DIV (TDIV)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural mtime, prescaler phase, expected responses.
  logic [63:0] m_time  = 64'd0;
  int          m_presc = 0;
  logic [34:0] rq[$];
  logic [1:0]  bq[$];
  int          wr_phase = 0;
  logic [31:0] m_waddr;
  logic [7:0]  m_wlen;
  logic        m_first;
  bit          prev_rstall = 0;
  logic [34:0] prev_r;
  bit          prev_bstall = 0;
  logic [1:0]  prev_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no handshake expected handshake within bound at %0t", name, $time);
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'd8);
  endfunction

  function automatic logic [34:0] exp_beat(input logic [31:0] a, input logic [63:0] t, input bit last);
    if (!in_win(a)) return {last, 2'b10, 32'd0};
    return {last, 2'b00, ((a - BASE) >= 32'd4) ? t[63:32] : t[31:0]};
  endfunction

  always @(negedge clk) begin : monitor
    logic [63:0] next_time;
    bit          wr_hit;
    logic [34:0] e;
    logic [1:0]  eb;
    if (!rst_n) begin
      check("rst_arready", bus.arready, 1'b1);
      check("rst_awready", bus.awready, 1'b1);
      check("rst_wready", bus.wready, 1'b0);
      check("rst_rvalid", bus.rvalid, 1'b0);
      check("rst_bvalid", bus.bvalid, 1'b0);
      check("rst_rlast", bus.rlast, 1'b0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_rresp", bus.rresp, 2'b00);
      check("rst_bresp", bus.bresp, 2'b00);
      rq.delete();
      bq.delete();
      m_time = 64'd0;
      m_presc = 0;
      wr_phase = 0;
      prev_rstall = 0;
      prev_bstall = 0;
    end else begin
      check("arready", bus.arready, rq.size() == 0);
      check("rvalid", bus.rvalid, rq.size() != 0);
      check("awready", bus.awready, wr_phase == 0);
      check("wready", bus.wready, wr_phase == 1);
      check("bvalid", bus.bvalid, wr_phase == 2);
      if (prev_rstall) check("r_stable", {bus.rlast, bus.rresp, bus.rdata}, prev_r);
      if (prev_bstall) check("b_stable", bus.bresp, prev_b);
      prev_rstall = bus.rvalid && !bus.rready;
      prev_r      = {bus.rlast, bus.rresp, bus.rdata};
      prev_bstall = bus.bvalid && !bus.bready;
      prev_b      = bus.bresp;

      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) begin
          fail_bound("r_unexpected");
        end else begin
          e = rq.pop_front();
          check("rdata", bus.rdata, e[31:0]);
          check("rresp", bus.rresp, e[33:32]);
          check("rlast", bus.rlast, e[34]);
        end
      end
      if (bus.arvalid && bus.arready) begin
        for (int i = 0; i <= int'(bus.arlen); i++)
          rq.push_back(exp_beat(bus.araddr + 32'(4 * i), m_time, i == int'(bus.arlen)));
      end

      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          fail_bound("b_unexpected");
        end else begin
          eb = bq.pop_front();
          check("bresp", bus.bresp, eb);
        end
        wr_phase = 0;
      end
      if (bus.awvalid && bus.awready) begin
        m_waddr  = bus.awaddr;
        m_wlen   = bus.awlen;
        m_first  = 1'b1;
        wr_phase = 1;
        bq.push_back(((bus.awlen != 8'd0) || !in_win(bus.awaddr)) ? 2'b10 : 2'b00);
      end
      wr_hit = 0;
      next_time = m_time;
      if (bus.wvalid && bus.wready) begin
        if (m_first && m_wlen == 8'd0 && in_win(m_waddr)) begin
          for (int b = 0; b < 4; b++)
            if (bus.wstrb[b])
              next_time[(((m_waddr - BASE) >= 32'd4) ? 32 : 0) + b*8 +: 8] = bus.wdata[b*8 +: 8];
          wr_hit = 1;
        end
        m_first = 1'b0;
        if (bus.wlast) wr_phase = 2;
      end

      if (wr_hit) m_time = next_time;
      else if (m_presc == TDIV - 1) m_time = m_time + 64'd1;
      m_presc = (m_presc == TDIV - 1) ? 0 : m_presc + 1;
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int hold);
    int guard;
    int beats;
    bit got;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = 3'd2;
    got = 0;
    guard = 0;
    while (!got && guard < 50) begin
      @(negedge clk);
      got = bus.arready;
      @(posedge clk); #1;
      guard++;
    end
    bus.arvalid = 1'b0;
    if (!got) begin
      fail_bound("ar_wait");
      return;
    end
    beats = 0;
    guard = 0;
    while (beats < int'(len) + 1 && guard < 400) begin
      if (hold > 0) begin
        bus.rready = 1'b0;
        hold--;
      end else begin
        bus.rready = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      if (bus.rvalid && bus.rready) beats++;
      @(posedge clk); #1;
      guard++;
    end
    bus.rready = 1'b0;
    if (beats < int'(len) + 1) fail_bound("r_wait");
    $display("read  addr=%h len=%0d beats=%0d", addr, len, beats);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] data, input logic [3:0] strb, input int hold);
    int guard;
    bit got;
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = 3'd2;
    got = 0;
    guard = 0;
    while (!got && guard < 50) begin
      @(negedge clk);
      got = bus.awready;
      @(posedge clk); #1;
      guard++;
    end
    bus.awvalid = 1'b0;
    if (!got) begin
      fail_bound("aw_wait");
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = (i == 0) ? data : $urandom;
      bus.wstrb  = strb;
      bus.wlast  = (i == int'(len));
      got = 0;
      guard = 0;
      while (!got && guard < 50) begin
        @(negedge clk);
        got = bus.wready;
        @(posedge clk); #1;
        guard++;
      end
      if (!got) begin
        bus.wvalid = 1'b0;
        fail_bound("w_wait");
        return;
      end
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    got = 0;
    guard = 0;
    while (!got && guard < 50) begin
      if (hold > 0) begin
        bus.bready = 1'b0;
        hold--;
      end else begin
        bus.bready = 1'b1;
      end
      @(negedge clk);
      got = bus.bvalid && bus.bready;
      @(posedge clk); #1;
      guard++;
    end
    bus.bready = 1'b0;
    if (!got) fail_bound("b_wait");
    $display("write addr=%h len=%0d data=%h strb=%b", addr, len, data, strb);
  endtask

  initial begin
    logic [31:0] a;
    bit got;
    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0;
    bus.wvalid = 0;  bus.wdata = 0;  bus.wstrb = 0; bus.wlast = 0;
    bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0;
    bus.rready = 0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end

    do_read(BASE, 8'd0, 0);
    do_write(BASE + 32'd4, 8'd0, 32'h0000_0005, 4'hF, 0);
    do_read(BASE, 8'd1, 0);
    do_write(BASE + 32'd4, 8'd0, 32'hFFFF_FFFF, 4'hF, 0);
    do_write(BASE, 8'd0, 32'hFFFF_FFFF, 4'hF, 0);
    do_read(BASE, 8'd1, 0);
    do_read(BASE + 32'h10, 8'd0, 0);
    do_read(BASE - 32'd4, 8'd0, 0);
    do_read(BASE + WIN, 8'd0, 0);
    do_write(BASE, 8'd2, 32'h1234_5678, 4'hF, 0);
    do_read(BASE, 8'd3, 0);
    do_read(BASE, 8'd0, 5);
    do_write(BASE, 8'd0, 32'h0000_0100, 4'b0011, 5);
    do_read(BASE, 8'd1, 0);

    // AR accepted on the same edge as the W beat: snapshot must be pre-write.
    fork
      do_write(BASE, 8'd0, 32'hABCD_0000, 4'b1100, 0);
      begin
        @(posedge clk); #1;
        do_read(BASE, 8'd1, 0);
      end
    join

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(5))
        0: a = BASE;
        1: a = BASE + 32'd4;
        2: a = BASE + 32'd8;
        3: a = BASE + 32'h10;
        4: a = BASE + WIN;
        default: a = BASE - 32'd4;
      endcase
      fork
        do_read(a, 8'($urandom_range(3)), $urandom_range(2));
        begin
          repeat ($urandom_range(2)) begin @(posedge clk); #1; end
          do_write(($urandom_range(3) == 0) ? a : BASE + 32'(4 * $urandom_range(1)),
                   ($urandom_range(3) == 0) ? 8'($urandom_range(1, 2)) : 8'd0,
                   $urandom, 4'($urandom), $urandom_range(2));
        end
      join
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
    end

    // Reset in the middle of a 4-beat burst, right after beat 0.
    bus.arvalid = 1'b1; bus.araddr = BASE; bus.arlen = 8'd3;
    got = 0;
    for (int g = 0; g < 50 && !got; g++) begin
      @(negedge clk);
      got = bus.arready;
      @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    if (!got) fail_bound("rst_ar_wait");
    bus.rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.rready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", bus.rvalid, 1'b0);
    check("mid_rst_arready", bus.arready, 1'b1);
    check("mid_rst_rlast", bus.rlast, 1'b0);
    $display("reset asserted mid-burst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    do_read(BASE, 8'd1, 0);
    repeat (3) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
